// File: rtl/usb_xact_sequencer.sv
// USB device transaction sequencer: decodes tokens, tracks per-endpoint data
// toggles and drives the handshake, IN-data and OUT-buffer strobes.
module usb_xact_sequencer #(
    parameter int NUM_EP  = 4,
    parameter int TIMEOUT = 816
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [6:0]        usb_addr_i,
    input  logic              tok_recv_i,
    input  logic [3:0]        tok_pid_i,
    input  logic [6:0]        tok_addr_i,
    input  logic [3:0]        tok_endp_i,
    input  logic              usb_recv_i,
    input  logic              crc_error_i,
    input  logic              hsk_recv_i,
    input  logic [3:0]        rx_pid_i,
    input  logic [NUM_EP-1:0] ep_rx_ready_i,
    input  logic [NUM_EP-1:0] ep_tx_avail_i,
    input  logic [NUM_EP-1:0] ep_stall_i,
    output logic              hsk_send_o,
    output logic [3:0]        hsk_pid_o,
    input  logic              hsk_done_i,
    output logic              tx_start_o,
    output logic [3:0]        tx_pid_o,
    input  logic              tx_done_i,
    output logic              rx_accept_o,
    output logic              rx_discard_o,
    output logic [3:0]        ep_sel_o,
    output logic              setup_o,
    output logic              busy_o
);
    localparam logic [3:0] PID_OUT   = 4'h1;
    localparam logic [3:0] PID_IN    = 4'h9;
    localparam logic [3:0] PID_SETUP = 4'hD;
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;
    localparam logic [3:0] PID_STALL = 4'hE;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(TIMEOUT);
    localparam logic [4:0] EP_LIMIT = 5'(NUM_EP);

    typedef enum logic [2:0] {IDLE, RX_DATA, SEND_HSK, TX_DATA, WAIT_ACK} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NUM_EP-1:0] tog_in_q, tog_in_d, tog_out_q, tog_out_d;
    logic              hsk_send_q, hsk_send_d;
    logic [3:0]        hsk_pid_q, hsk_pid_d;
    logic              tx_start_q, tx_start_d;
    logic [3:0]        tx_pid_q, tx_pid_d;
    logic              rx_accept_q, rx_accept_d;
    logic              rx_discard_q, rx_discard_d;
    logic [3:0]        ep_sel_q, ep_sel_d;
    logic              setup_q, setup_d;
    logic              busy_q, busy_d;

    // One-hot endpoint decodes keep all per-endpoint lookups free of wide indexing
    logic [NUM_EP-1:0] tok_hit, cur_hit;
    genvar gi;
    generate
        for (gi = 0; gi < NUM_EP; gi++) begin : g_ep_dec
            assign tok_hit[gi] = (tok_endp_i == 4'(gi));
            assign cur_hit[gi] = (ep_sel_q == 4'(gi));
        end
    endgenerate

    logic tok_ok, tok_stall, tok_avail, tok_in_tog;
    logic cur_stall, cur_ready, cur_out_tog;
    logic rx_is_data, cnt_expire;

    assign tok_ok      = tok_recv_i && (tok_addr_i == usb_addr_i)
                         && ({1'b0, tok_endp_i} < EP_LIMIT);
    assign tok_stall   = |(ep_stall_i & tok_hit);
    assign tok_avail   = |(ep_tx_avail_i & tok_hit);
    assign tok_in_tog  = |(tog_in_q & tok_hit);
    assign cur_stall   = |(ep_stall_i & cur_hit);
    assign cur_ready   = |(ep_rx_ready_i & cur_hit);
    assign cur_out_tog = |(tog_out_q & cur_hit);
    assign rx_is_data  = (rx_pid_i == PID_DATA0) || (rx_pid_i == PID_DATA1);
    assign cnt_expire  = (cnt_q <= CW'(1));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tog_in_d     = tog_in_q;
        tog_out_d    = tog_out_q;
        hsk_send_d   = hsk_send_q;
        hsk_pid_d    = hsk_pid_q;
        tx_start_d   = tx_start_q;
        tx_pid_d     = tx_pid_q;
        rx_accept_d  = 1'b0;
        rx_discard_d = 1'b0;
        ep_sel_d     = ep_sel_q;
        setup_d      = setup_q;
        case (state_q)
            IDLE: begin
                if (tok_ok && (tok_pid_i == PID_OUT || tok_pid_i == PID_SETUP)) begin
                    ep_sel_d = tok_endp_i;
                    setup_d  = (tok_pid_i == PID_SETUP);
                    cnt_d    = CNT_LOAD;
                    state_d  = RX_DATA;
                end else if (tok_ok && tok_pid_i == PID_IN) begin
                    ep_sel_d = tok_endp_i;
                    setup_d  = 1'b0;
                    if (tok_stall || !tok_avail) begin
                        hsk_send_d = 1'b1;
                        hsk_pid_d  = tok_stall ? PID_STALL : PID_NAK;
                        state_d    = SEND_HSK;
                    end else begin
                        tx_start_d = 1'b1;
                        tx_pid_d   = tok_in_tog ? PID_DATA1 : PID_DATA0;
                        state_d    = TX_DATA;
                    end
                end
            end
            RX_DATA: begin
                cnt_d = cnt_q - CW'(1);
                if (crc_error_i || (usb_recv_i && !rx_is_data)
                    || (usb_recv_i && setup_q && rx_pid_i != PID_DATA0)
                    || (!usb_recv_i && cnt_expire)) begin
                    rx_discard_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = IDLE;
                end else if (usb_recv_i) begin
                    cnt_d      = '0;
                    hsk_send_d = 1'b1;
                    hsk_pid_d  = PID_ACK;
                    state_d    = SEND_HSK;
                    if (setup_q) begin
                        rx_accept_d = 1'b1;
                        tog_in_d    = tog_in_q | cur_hit;
                        tog_out_d   = tog_out_q | cur_hit;
                    end else if (cur_stall) begin
                        rx_discard_d = 1'b1;
                        hsk_pid_d    = PID_STALL;
                    end else if (!cur_ready) begin
                        rx_discard_d = 1'b1;
                        hsk_pid_d    = PID_NAK;
                    end else if ((rx_pid_i == PID_DATA1) == cur_out_tog) begin
                        rx_accept_d = 1'b1;
                        tog_out_d   = tog_out_q ^ cur_hit;
                    end else begin
                        // Host missed our previous ACK: re-ACK without committing again
                        rx_discard_d = 1'b1;
                    end
                end
            end
            SEND_HSK: begin
                if (hsk_done_i) begin
                    hsk_send_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            TX_DATA: begin
                if (tx_done_i) begin
                    tx_start_d = 1'b0;
                    cnt_d      = CNT_LOAD;
                    state_d    = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                cnt_d = cnt_q - CW'(1);
                if (hsk_recv_i || tok_recv_i || cnt_expire) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (hsk_recv_i && rx_pid_i == PID_ACK) begin
                        tog_in_d = tog_in_q ^ cur_hit;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            tog_in_q     <= '0;
            tog_out_q    <= '0;
            hsk_send_q   <= 1'b0;
            hsk_pid_q    <= 4'h0;
            tx_start_q   <= 1'b0;
            tx_pid_q     <= 4'h0;
            rx_accept_q  <= 1'b0;
            rx_discard_q <= 1'b0;
            ep_sel_q     <= 4'h0;
            setup_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tog_in_q     <= tog_in_d;
            tog_out_q    <= tog_out_d;
            hsk_send_q   <= hsk_send_d;
            hsk_pid_q    <= hsk_pid_d;
            tx_start_q   <= tx_start_d;
            tx_pid_q     <= tx_pid_d;
            rx_accept_q  <= rx_accept_d;
            rx_discard_q <= rx_discard_d;
            ep_sel_q     <= ep_sel_d;
            setup_q      <= setup_d;
            busy_q       <= busy_d;
        end
    end

    assign hsk_send_o   = hsk_send_q;
    assign hsk_pid_o    = hsk_pid_q;
    assign tx_start_o   = tx_start_q;
    assign tx_pid_o     = tx_pid_q;
    assign rx_accept_o  = rx_accept_q;
    assign rx_discard_o = rx_discard_q;
    assign ep_sel_o     = ep_sel_q;
    assign setup_o      = setup_q;
    assign busy_o       = busy_q;
endmodule

// File: tb/tb_usb_xact_sequencer.sv
// Randomized scoreboard bench for usb_xact_sequencer: a toggle-tracking model
// queues expected strobes, a negedge monitor pops and compares them.
module tb_usb_xact_sequencer;
    localparam int NUM_EP  = 4;
    localparam int TIMEOUT = 24;
    localparam logic [3:0] P_OUT = 4'h1, P_IN = 4'h9, P_SETUP = 4'hD, P_SOF = 4'h5, P_PING = 4'h4;
    localparam logic [3:0] P_D0 = 4'h3, P_D1 = 4'hB, P_ACK = 4'h2, P_NAK = 4'hA, P_STALL = 4'hE;
    localparam int K_ACC = 0, K_DIS = 1, K_HSK = 2, K_TX = 3;
    localparam int PK_DATA = 0, PK_CRC = 1, PK_TMO = 2;
    localparam int R_ACK = 0, R_OTHER = 1, R_TOKEN = 2, R_NONE = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [6:0] usb_addr_i = 7'h0;
    logic tok_recv_i = 1'b0;
    logic [3:0] tok_pid_i = 4'h0;
    logic [6:0] tok_addr_i = 7'h0;
    logic [3:0] tok_endp_i = 4'h0;
    logic usb_recv_i = 1'b0, crc_error_i = 1'b0, hsk_recv_i = 1'b0;
    logic [3:0] rx_pid_i = 4'h0;
    logic [NUM_EP-1:0] ep_rx_ready_i = '0, ep_tx_avail_i = '0, ep_stall_i = '0;
    logic hsk_send_o, tx_start_o, rx_accept_o, rx_discard_o, setup_o, busy_o;
    logic [3:0] hsk_pid_o, tx_pid_o, ep_sel_o;
    logic hsk_done_i, tx_done_i;

    usb_xact_sequencer #(.NUM_EP(NUM_EP), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset), .usb_addr_i(usb_addr_i),
        .tok_recv_i(tok_recv_i), .tok_pid_i(tok_pid_i), .tok_addr_i(tok_addr_i),
        .tok_endp_i(tok_endp_i), .usb_recv_i(usb_recv_i), .crc_error_i(crc_error_i),
        .hsk_recv_i(hsk_recv_i), .rx_pid_i(rx_pid_i), .ep_rx_ready_i(ep_rx_ready_i),
        .ep_tx_avail_i(ep_tx_avail_i), .ep_stall_i(ep_stall_i),
        .hsk_send_o(hsk_send_o), .hsk_pid_o(hsk_pid_o), .hsk_done_i(hsk_done_i),
        .tx_start_o(tx_start_o), .tx_pid_o(tx_pid_o), .tx_done_i(tx_done_i),
        .rx_accept_o(rx_accept_o), .rx_discard_o(rx_discard_o), .ep_sel_o(ep_sel_o),
        .setup_o(setup_o), .busy_o(busy_o)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int txn = 0;
    bit auto_resp = 1'b1;
    bit in_tog[NUM_EP];
    bit out_tog[NUM_EP];

    typedef struct {
        int         kind;
        logic [3:0] val;
        int         cyc;
        logic [3:0] ep;
        logic       setup;
    } ev_t;
    ev_t exp_q[$];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic bit pick(input logic [NUM_EP-1:0] v, input int i);
        logic [NUM_EP-1:0] s;
        s = v >> i;
        return s[0];
    endfunction

    task automatic push(input int kind, input logic [3:0] val, input int c, input int ep, input bit setup);
        ev_t e;
        e.kind = kind; e.val = val; e.cyc = c; e.ep = 4'(ep); e.setup = setup;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input int kind, input logic [3:0] val);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event got kind=%0d pid=%h cyc=%0d, required none", kind, val, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != val || e.cyc != cyc || e.ep != ep_sel_o || e.setup != setup_o) begin
                fails++;
                $display("FAIL event got kind=%0d pid=%h cyc=%0d ep=%0d setup=%0d, required kind=%0d pid=%h cyc=%0d ep=%0d setup=%0d",
                         kind, val, cyc, ep_sel_o, setup_o, e.kind, e.val, e.cyc, e.ep, e.setup);
            end
        end
    endtask

    // Monitor: every strobe or request edge the DUT emits must match the queue head
    initial begin
        bit hsk_prev;
        bit tx_prev;
        logic [3:0] pid_prev;
        hsk_prev = 1'b0; tx_prev = 1'b0; pid_prev = 4'h0;
        forever begin
            @(negedge clock);
            if (rx_accept_o || rx_discard_o) begin
                tests++;
                if (rx_accept_o && rx_discard_o) begin
                    fails++;
                    $display("FAIL accept_discard_exclusive got both=1, required at most one");
                end
            end
            if (rx_accept_o) check_ev(K_ACC, 4'h0);
            if (rx_discard_o) check_ev(K_DIS, 4'h0);
            if (hsk_send_o && !hsk_prev) check_ev(K_HSK, hsk_pid_o);
            if (hsk_send_o && hsk_prev) begin
                tests++;
                if (hsk_pid_o != pid_prev) begin
                    fails++;
                    $display("FAIL hsk_pid_hold got=%h required=%h", hsk_pid_o, pid_prev);
                end
            end
            if (tx_start_o && !tx_prev) check_ev(K_TX, tx_pid_o);
            hsk_prev = hsk_send_o; tx_prev = tx_start_o; pid_prev = hsk_pid_o;
        end
    end

    // PHY model: completes a requested handshake / IN packet after a random delay
    initial begin
        hsk_done_i = 1'b0;
        tx_done_i  = 1'b0;
        forever begin
            @(negedge clock);
            if (auto_resp && !reset && (hsk_send_o || tx_start_o)) begin
                bit is_hsk;
                is_hsk = hsk_send_o;
                repeat ($urandom_range(0, 2)) @(negedge clock);
                @(posedge clock);
                #1;
                if (is_hsk) hsk_done_i = 1'b1;
                else tx_done_i = 1'b1;
                @(posedge clock);
                #1;
                hsk_done_i = 1'b0;
                tx_done_i  = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic send_token(input logic [3:0] pid, input logic [6:0] addr, input int ep, output int e);
        tok_pid_i = pid; tok_addr_i = addr; tok_endp_i = 4'(ep); tok_recv_i = 1'b1;
        e = cyc + 1;
        tick();
        tok_recv_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy_o && n < TIMEOUT + 20) begin
            tick();
            n++;
        end
        tests++;
        if (busy_o) begin
            fails++;
            $display("FAIL %s_return_idle busy_o got=1 required=0", tag);
        end
        tick();
    endtask

    task automatic do_out(input int ep, input bit setup, input int kind, input logic [3:0] pid,
                          input logic [NUM_EP-1:0] stall_v, input logic [NUM_EP-1:0] ready_v);
        int e, d, dummy;
        txn++;
        $display("[TB] txn %0d: %s ep%0d kind=%0d pid=%h stall=%b ready=%b",
                 txn, setup ? "SETUP" : "OUT", ep, kind, pid, stall_v, ready_v);
        ep_stall_i = stall_v;
        ep_rx_ready_i = ready_v;
        send_token(setup ? P_SETUP : P_OUT, usb_addr_i, ep, e);
        if (kind == PK_TMO) begin
            push(K_DIS, 4'h0, e + TIMEOUT, ep, setup);
        end else begin
            // Tokens arriving while a data packet is awaited must have no effect
            repeat ($urandom_range(0, 3)) begin
                if ($urandom_range(0, 3) == 0) send_token(P_IN, usb_addr_i, $urandom_range(0, NUM_EP - 1), dummy);
                else tick();
            end
            d = cyc + 1;
            if (kind == PK_CRC || (pid != P_D0 && pid != P_D1)) begin
                push(K_DIS, 4'h0, d, ep, setup);
            end else if (setup) begin
                push(K_ACC, 4'h0, d, ep, setup);
                push(K_HSK, P_ACK, d, ep, setup);
                in_tog[ep] = 1'b1;
                out_tog[ep] = 1'b1;
            end else if (pick(stall_v, ep)) begin
                push(K_DIS, 4'h0, d, ep, setup);
                push(K_HSK, P_STALL, d, ep, setup);
            end else if (!pick(ready_v, ep)) begin
                push(K_DIS, 4'h0, d, ep, setup);
                push(K_HSK, P_NAK, d, ep, setup);
            end else if ((pid == P_D1) == out_tog[ep]) begin
                push(K_ACC, 4'h0, d, ep, setup);
                push(K_HSK, P_ACK, d, ep, setup);
                out_tog[ep] = !out_tog[ep];
            end else begin
                push(K_DIS, 4'h0, d, ep, setup);
                push(K_HSK, P_ACK, d, ep, setup);
            end
            rx_pid_i = pid;
            crc_error_i = (kind == PK_CRC);
            usb_recv_i = (kind == PK_CRC) ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            usb_recv_i = 1'b0;
            crc_error_i = 1'b0;
        end
        wait_idle("out");
    endtask

    task automatic do_in(input int ep, input logic [NUM_EP-1:0] stall_v,
                         input logic [NUM_EP-1:0] avail_v, input int reply);
        int e, n, dummy;
        txn++;
        $display("[TB] txn %0d: IN ep%0d stall=%b avail=%b reply=%0d", txn, ep, stall_v, avail_v, reply);
        ep_stall_i = stall_v;
        ep_tx_avail_i = avail_v;
        send_token(P_IN, usb_addr_i, ep, e);
        if (pick(stall_v, ep)) begin
            push(K_HSK, P_STALL, e, ep, 1'b0);
        end else if (!pick(avail_v, ep)) begin
            push(K_HSK, P_NAK, e, ep, 1'b0);
        end else begin
            push(K_TX, in_tog[ep] ? P_D1 : P_D0, e, ep, 1'b0);
            n = 0;
            while (tx_start_o && n < 20) begin
                tick();
                n++;
            end
            tests++;
            if (tx_start_o) begin
                fails++;
                $display("FAIL tx_start_release got=1 required=0");
            end
            repeat ($urandom_range(0, 2)) tick();
            case (reply)
                R_ACK: begin
                    rx_pid_i = P_ACK; hsk_recv_i = 1'b1; tick(); hsk_recv_i = 1'b0;
                    in_tog[ep] = !in_tog[ep];
                end
                R_OTHER: begin
                    rx_pid_i = ($urandom_range(0, 1) == 1) ? P_NAK : P_STALL;
                    hsk_recv_i = 1'b1; tick(); hsk_recv_i = 1'b0;
                end
                R_TOKEN: send_token(($urandom_range(0, 1) == 1) ? P_IN : P_OUT, usb_addr_i,
                                    $urandom_range(0, NUM_EP - 1), dummy);
                default: ;
            endcase
        end
        wait_idle("in");
    endtask

    task automatic do_ignored(input int mode);
        int e, ep;
        logic [6:0] addr;
        logic [3:0] pid;
        addr = usb_addr_i;
        ep = $urandom_range(0, NUM_EP - 1);
        pid = ($urandom_range(0, 1) == 1) ? P_IN : P_OUT;
        if (mode == 0) addr = usb_addr_i ^ 7'($urandom_range(1, 127));
        else if (mode == 1) ep = $urandom_range(NUM_EP, 15);
        else pid = ($urandom_range(0, 1) == 1) ? P_SOF : P_PING;
        txn++;
        $display("[TB] txn %0d: ignored token mode=%0d pid=%h addr=%h ep%0d", txn, mode, pid, addr, ep);
        ep_stall_i = '0;
        ep_tx_avail_i = '1;
        ep_rx_ready_i = '1;
        send_token(pid, addr, ep, e);
        tests++;
        if (busy_o) begin
            fails++;
            $display("FAIL ignored_token busy_o got=1 required=0");
        end
        repeat (3) tick();
    endtask

    initial begin
        int e;
        logic [NUM_EP-1:0] sv, av, rv;
        logic [3:0] pid;
        int sel, r;
        for (int i = 0; i < NUM_EP; i++) begin
            in_tog[i] = 1'b0;
            out_tog[i] = 1'b0;
        end
        usb_addr_i = 7'($urandom_range(1, 127));
        repeat (3) tick();
        tests++;
        if ({hsk_send_o, tx_start_o, rx_accept_o, rx_discard_o, setup_o, busy_o,
             hsk_pid_o, tx_pid_o, ep_sel_o} != '0) begin
            fails++;
            $display("FAIL reset_outputs got nonzero, required all 0");
        end
        reset = 1'b0;
        tick();

        do_out(0, 1'b1, PK_DATA, P_D0, '0, '1);
        do_in(0, '0, '1, R_ACK);
        do_out(1, 1'b0, PK_DATA, P_D0, '0, '1);
        do_out(1, 1'b0, PK_DATA, P_D0, '0, '1);
        do_in(2, '0, '0, R_NONE);
        do_in(2, '0, '1, R_ACK);
        do_in(2, '0, '1, R_ACK);
        do_in(3, '0, '1, R_NONE);
        do_in(3, '0, '1, R_ACK);
        do_ignored(0);
        do_ignored(1);
        do_ignored(2);
        do_out(1, 1'b0, PK_DATA, P_D1, 4'b0010, '1);

        // Reset while a STALL handshake is being held
        txn++;
        $display("[TB] txn %0d: IN ep2 stalled, reset during hsk_send", txn);
        auto_resp = 1'b0;
        ep_stall_i = 4'b0100;
        send_token(P_IN, usb_addr_i, 2, e);
        push(K_HSK, P_STALL, e, 2, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        tests++;
        if ({hsk_send_o, tx_start_o, rx_accept_o, rx_discard_o, setup_o, busy_o,
             hsk_pid_o, tx_pid_o, ep_sel_o} != '0) begin
            fails++;
            $display("FAIL reset_abort got nonzero outputs, required all 0");
        end
        reset = 1'b0;
        for (int i = 0; i < NUM_EP; i++) begin
            in_tog[i] = 1'b0;
            out_tog[i] = 1'b0;
        end
        ep_stall_i = '0;
        auto_resp = 1'b1;
        tick();

        for (int i = 0; i < 250; i++) begin
            sel = $urandom_range(0, 9);
            sv = NUM_EP'($urandom) & NUM_EP'($urandom) & NUM_EP'($urandom);
            av = NUM_EP'($urandom) | NUM_EP'($urandom);
            rv = NUM_EP'($urandom) | NUM_EP'($urandom);
            r = $urandom_range(0, 7);
            if (sel <= 4) begin
                if (r == 0) pid = 4'h7;
                else if (r == 1) pid = 4'hF;
                else if (sel == 4 || (r % 2) == 0) pid = P_D0;
                else pid = P_D1;
                r = $urandom_range(0, 9);
                do_out($urandom_range(0, NUM_EP - 1), sel == 4,
                       (r == 0) ? PK_CRC : ((r == 1) ? PK_TMO : PK_DATA), pid, sv, rv);
            end else if (sel <= 8) begin
                do_in($urandom_range(0, NUM_EP - 1), sv, av, $urandom_range(0, 3));
            end else begin
                do_ignored($urandom_range(0, 2));
            end
        end

        repeat (5) tick();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got %0d pending events, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
